timer_compare_irq: RTL
======================

# timer_compare_irq

Consumer side of the timer counter. It samples the free-running 64-bit count, compares it against a 64-bit compare value written as two 32-bit halves, and raises a sticky interrupt status on each new match. Software clears the status with a write-1-to-clear pulse. An optional periodic mode advances the compare value by a programmable period on every match. The block sits between the counter and the register/APB decode and owns `TCMP`, `TPRD`, the interrupt status and the interrupt output.

## Interface
Parameters:
- `CNT_W`, 64, count and compare width.
- `BUS_W`, 32, write-data width. `CNT_W` must equal `2*BUS_W`.

Ports:
- `sys_clk`  in  1  system clock.
- `sys_rst`  in  1  reset; synchronous and active-high.
- `cnt`  in  CNT_W  current counter value, registered by the counter.
- `timer_en`  in  1  timer enable. Matching is suppressed while it is 0.
- `wdata`  in  BUS_W  register write data.
- `cmp_wr_lo`  in  1  write `wdata` to the compare low shadow.
- `cmp_wr_hi`  in  1  write `wdata` to compare high and commit both halves.
- `prd_wr`  in  1  write `wdata` to `TPRD`.
- `periodic`  in  1  1 = auto-advance `TCMP` on each match.
- `int_en`  in  1  interrupt output mask.
- `int_clr`  in  1  one-cycle write-1-to-clear pulse for `int_st`.
- `tcmp`  out  CNT_W  committed compare value, for readback.
- `tprd`  out  BUS_W  period register.
- `int_st`  out  1  sticky interrupt status.
- `tim_int`  out  1  `int_st & int_en`; combinational from flops only.

## Operation
Reset values:
- `tcmp` = all ones.
- `lo_shadow` = 0.
- `tprd` = 0.
- `int_st` = 0.
- `match_q` = 0.
- `tim_int` = 0.

Compare write (atomic update):
- `cmp_wr_lo` loads only `lo_shadow`. `tcmp` is unchanged.
- `cmp_wr_hi` loads `tcmp <= {wdata, lo_shadow}` in one cycle.
- If `cmp_wr_lo` and `cmp_wr_hi` are asserted together, `tcmp <= {wdata, wdata}` and the shadow is also updated.

Match detection:
- `match = timer_en & (cnt == tcmp)`.
- `match_q <= match` every cycle.
- A match event is the rising edge `match & ~match_q`.
- A halted counter held at the compare value therefore produces exactly one event.

Status:
- On a match event, `int_st <= 1`.
- On `int_clr`, `int_st <= 0`.
- A match event and `int_clr` in the same cycle leave `int_st` = 1 (set wins).

Periodic mode:
- When `periodic` = 1, each match event also performs `tcmp <= tcmp + zero_extend(tprd)`, modulo 2^CNT_W with silent wrap.
- If `cmp_wr_hi` and the auto-advance occur in the same cycle, the software write wins.
- With `tprd` = 0, `tcmp` does not move. Only one event fires, because `match` stays high.

Writing `tcmp` to the current `cnt` value while `timer_en` = 1 yields a match event on the next cycle. No event is missed or duplicated.

`timer_en` = 0 forces `match` to 0. `tcmp`, `tprd` and `int_st` are retained.

## Timing
- Match latency: `cnt == tcmp` is visible in cycle N; `int_st` and `tim_int` rise in cycle N+1.
- Periodic advance: the new `tcmp` is visible in cycle N+1, together with `int_st`.
- Clear latency: `int_clr` in cycle N gives `int_st` = 0 in cycle N+1.
- Compare commit: `cmp_wr_hi` in cycle N gives new `tcmp` in cycle N+1. The first compare against the new value happens in cycle N+1.
- `int_en` masks `tim_int` combinationally with no added latency. `int_st` still records events while masked.
- `sys_rst` asserted mid-operation returns every flop to its reset value on the next edge, and drops a pending interrupt.

## Structure
- `timer_pkg` holds:
  - `TCMP_RST` (all ones), `TPRD_RST`
  - the `CNT_W` / `BUS_W` defaults
- One sub-module, `timer_cmp_match`:
  - contains the equality compare, the `timer_en` gate, `match_q` and the rising-edge output `match_evt`;
  - the top level holds the register file, the periodic adder and the status logic.

## Test plan
1. Reset, then write lo = `0x10`, hi = `0x0` with `timer_en` = 1, and ramp `cnt` from 0. Required: `int_st` rises the cycle after `cnt` = `0x10`, and `tim_int` = 1 with `int_en` = 1.
2. Write lo = `0x20` only. Required: `tcmp` unchanged, so no match at `cnt` = `0x20`. Then write hi = `0`. Required: `tcmp` = `0x20`.
3. Hold `cnt` = `0x30` = `tcmp` for 10 cycles and pulse `int_clr` in cycle 5. Required: exactly one set, and `int_st` stays 0 after the clear. Then pulse `int_clr` on the same cycle as a new match event. Required: `int_st` = 1.
4. `periodic` = 1, `tprd` = `0x100`, `tcmp` = `0x100`, ramp `cnt` to `0x400`. Required: events at `0x100`, `0x200`, `0x300` and `0x400`, with `tcmp` = `0x500` at the end.
5. `tcmp` = `0xFFFF_FFFF_FFFF_FF80` with `tprd` = `0x100`. Required: after the match, `tcmp` = `0x80` (wrap). `cnt` wrapping past 0 to `0x80` produces the next event.
6. `timer_en` = 0 with `cnt` = `tcmp`. Required: no event. Assert `sys_rst` while `int_st` = 1. Required: all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants for the timer compare block: default widths and register reset values.
// Latency: none (constants only).
// Backpressure: none.
package timer_pkg;

  localparam int CNT_W_DEF = 64;
  localparam int BUS_W_DEF = 32;

  // Compare resets to all ones so a counter starting from zero does not match for a very long time.
  localparam logic [CNT_W_DEF-1:0] TCMP_RST = '1;
  localparam logic [BUS_W_DEF-1:0] TPRD_RST = '0;

endpackage

// File: rtl/timer_cmp_match.sv
// Gated equality compare of count against compare value, with a one-cycle rising-edge event.
// Latency: match_evt is combinational from cnt/tcmp/timer_en and the registered previous match.
// Backpressure: none; evaluated every cycle, a held match yields a single event.
module timer_cmp_match
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] tcmp,
  input  logic             timer_en,
  output logic             match_evt
);

  logic match_d;
  logic match_q;

  // Current-cycle match, suppressed while the timer is disabled; event is its rising edge.
  always_comb begin
    match_d   = timer_en & (cnt == tcmp);
    match_evt = match_d & ~match_q;
  end

  // Remember last cycle's match so a held equality fires only once.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

endmodule

// File: rtl/timer_compare_irq.sv
// Compare register file (atomic lo/hi commit), period register, periodic auto-advance and sticky interrupt status.
// Latency: match in cycle N sets int_st / advances tcmp in N+1; writes and clears take effect in N+1.
// Backpressure: none; all writes are single-cycle pulses, always accepted. CNT_W must equal 2*BUS_W.
module timer_compare_irq
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int BUS_W = BUS_W_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [CNT_W-1:0] cnt,
  input  logic             timer_en,
  input  logic [BUS_W-1:0] wdata,
  input  logic             cmp_wr_lo,
  input  logic             cmp_wr_hi,
  input  logic             prd_wr,
  input  logic             periodic,
  input  logic             int_en,
  input  logic             int_clr,
  output logic [CNT_W-1:0] tcmp,
  output logic [BUS_W-1:0] tprd,
  output logic             int_st,
  output logic             tim_int
);

  localparam int EXT_W = CNT_W - BUS_W;

  logic [BUS_W-1:0] lo_shadow_d, lo_shadow_q;
  logic [CNT_W-1:0] tcmp_d, tcmp_q;
  logic [BUS_W-1:0] tprd_d, tprd_q;
  logic             int_st_d, int_st_q;
  logic             match_evt;

  timer_cmp_match #(
    .CNT_W (CNT_W)
  ) u_match (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .cnt       (cnt),
    .tcmp      (tcmp_q),
    .timer_en  (timer_en),
    .match_evt (match_evt)
  );

  // Next-state for registers: software compare write overrides the periodic advance; set beats clear.
  always_comb begin
    lo_shadow_d = lo_shadow_q;
    tprd_d      = tprd_q;
    tcmp_d      = tcmp_q;
    int_st_d    = int_st_q;

    if (cmp_wr_lo) begin
      lo_shadow_d = wdata;
    end
    if (prd_wr) begin
      tprd_d = wdata;
    end

    if (cmp_wr_hi) begin
      // A simultaneous lo write commits the new low half directly rather than the stale shadow.
      tcmp_d = {wdata, (cmp_wr_lo ? wdata : lo_shadow_q)};
    end else if (match_evt && periodic) begin
      tcmp_d = tcmp_q + {{EXT_W{1'b0}}, tprd_q};
    end

    if (int_clr) begin
      int_st_d = 1'b0;
    end
    if (match_evt) begin
      int_st_d = 1'b1;
    end
  end

  // Register file and status flops.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      lo_shadow_q <= '0;
      tcmp_q      <= TCMP_RST[CNT_W-1:0];
      tprd_q      <= TPRD_RST[BUS_W-1:0];
      int_st_q    <= 1'b0;
    end else begin
      lo_shadow_q <= lo_shadow_d;
      tcmp_q      <= tcmp_d;
      tprd_q      <= tprd_d;
      int_st_q    <= int_st_d;
    end
  end

  // Outputs straight from flops; interrupt mask adds no latency.
  always_comb begin
    tcmp    = tcmp_q;
    tprd    = tprd_q;
    int_st  = int_st_q;
    tim_int = int_st_q & int_en;
  end

endmodule
